// File: rtl/parity_step_counter.sv
// Mode-selectable counter: even, odd, step-up or step-down counting with load,
// enable, wrap/saturate policy and a registered overflow pulse.
module parity_step_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              En,
    input  logic              Load,
    input  logic [WIDTH-1:0]  D,
    input  logic [1:0]        Mode,
    input  logic [STEP_W-1:0] Step,
    input  logic              Sat,
    output logic [WIDTH-1:0]  Q,
    output logic              Ovf
);

    localparam logic [1:0] MODE_EVEN = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    localparam logic [WIDTH:0] EXT_TWO = {{(WIDTH-1){1'b0}}, 2'b10};

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   nxt;
    logic             ovf_evt;

    // Clamp target when a step leaves the representable range in saturate mode.
    function automatic logic [WIDTH-1:0] sat_value(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_EVEN: v = {{(WIDTH-1){1'b1}}, 1'b0};
            MODE_DOWN: v = '0;
            default:   v = '1;
        endcase
        return v;
    endfunction

    assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, Step};

    always_comb begin
        nxt = {1'b0, q_q};
        case (Mode)
            MODE_EVEN: nxt = {1'b0, q_q[WIDTH-1:1], 1'b0} + EXT_TWO;
            MODE_ODD:  nxt = {1'b0, q_q[WIDTH-1:1], 1'b1} + (q_q[0] ? EXT_TWO : '0);
            MODE_UP:   nxt = {1'b0, q_q} + step_ext;
            MODE_DOWN: nxt = {1'b0, q_q} - step_ext;
            default:   nxt = {1'b0, q_q};
        endcase
        // Bit WIDTH is the carry for the up modes and the borrow for step-down.
        ovf_evt = nxt[WIDTH];
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (Load) begin
            q_d = D;
        end else if (En) begin
            ovf_d = ovf_evt;
            if (ovf_evt && Sat) begin
                q_d = sat_value(Mode);
            end else begin
                q_d = nxt[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign Ovf = ovf_q;

endmodule
